vga_write_scheduler: RTL and testbench

VGA_WRITE_SCHEDULER -- requirements
Module: vga_write_scheduler

---
 rtl/vga_write_scheduler_pkg.sv | 34 +++
 rtl/vga_write_scheduler_if.sv | 40 ++++
 rtl/vga_write_scheduler_rr_pick.sv | 35 +++
 rtl/vga_write_scheduler.sv | 159 +++++++++++++++
 tb/tb_vga_write_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_write_scheduler_pkg.sv
// Shared definitions for the VGA write scheduler.
// Holds the default geometry (coordinate and colour widths), the scheduler
// state encoding, the stall limit for abandoned bursts and the fixed
// requester indices of the game's pixel writers.
package vga_write_scheduler_pkg;

  localparam int NREQ_DEFAULT        = 4;
  localparam int NX_DEFAULT          = 10;
  localparam int NY_DEFAULT          = 9;
  localparam int COLOR_DEPTH_DEFAULT = 9;
  localparam int MAX_BURST_DEFAULT   = 1024;

  // A granted requester that keeps req low this many HOLD cycles in a row
  // is treated as having abandoned its burst.
  localparam int STALL_LIMIT = 16;

  // Requester slots.
  localparam int REQ_PLAYER   = 0;
  localparam int REQ_OBSTACLE = 1;
  localparam int REQ_SCORE    = 2;
  localparam int REQ_BANNER   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  // Width of a requester index; never zero so a single requester still
  // gets a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_write_scheduler_if.sv
// Bundle between the pixel writers and the scheduler.
//   master : requester side  -- drives req/last/x_in/y_in/color_in,
//            observes grant, the VGA write port, owner and busy.
//   slave  : scheduler side  -- the opposite directions.
// Per-requester fields are packed, requester i at [i*W +: W].
interface vga_write_scheduler_if #(
  parameter int NREQ        = vga_write_scheduler_pkg::NREQ_DEFAULT,
  parameter int nX          = vga_write_scheduler_pkg::NX_DEFAULT,
  parameter int nY          = vga_write_scheduler_pkg::NY_DEFAULT,
  parameter int COLOR_DEPTH = vga_write_scheduler_pkg::COLOR_DEPTH_DEFAULT
);
  import vga_write_scheduler_pkg::*;

  localparam int OWNER_W = idx_w(NREQ);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             last;
  logic [NREQ*nX-1:0]          x_in;
  logic [NREQ*nY-1:0]          y_in;
  logic [NREQ*COLOR_DEPTH-1:0] color_in;

  logic [NREQ-1:0]             grant;
  logic [nX-1:0]               VGA_x;
  logic [nY-1:0]               VGA_y;
  logic [COLOR_DEPTH-1:0]      VGA_color;
  logic                        VGA_write;
  logic [OWNER_W-1:0]          owner;
  logic                        busy;

  modport master (
    output req, last, x_in, y_in, color_in,
    input  grant, VGA_x, VGA_y, VGA_color, VGA_write, owner, busy
  );

  modport slave (
    input  req, last, x_in, y_in, color_in,
    output grant, VGA_x, VGA_y, VGA_color, VGA_write, owner, busy
  );

endinterface

// File: rtl/vga_write_scheduler_rr_pick.sv
// Combinational round-robin first-one finder.
//   req_i   : request vector
//   ptr_i   : index where the scan starts (highest priority this round)
//   valid_o : some request is asserted
//   sel_o   : first asserted request at or after ptr_i, wrapping around
module vga_write_scheduler_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] sel_o
);

  int               idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    sel_o   = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDX_W'(idx);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        sel_o   = cand;
      end
    end
  end

endmodule

// File: rtl/vga_write_scheduler.sv
// Arbitrates NREQ pixel writers onto the single vga_adapter write port.
// A requester is granted a burst; each cycle it holds grant with req high,
// its pixel is accepted and appears registered on VGA_x/VGA_y/VGA_color
// with VGA_write one cycle later. The burst ends on a pixel flagged last,
// on the MAX_BURST-th pixel, or after STALL_LIMIT consecutive idle HOLD
// cycles; the round-robin pointer then moves past the old owner.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : slave side of vga_write_scheduler_if (requests, pixel lanes,
//            grant, VGA write port, owner, busy)
module vga_write_scheduler #(
  parameter int NREQ        = vga_write_scheduler_pkg::NREQ_DEFAULT,
  parameter int nX          = vga_write_scheduler_pkg::NX_DEFAULT,
  parameter int nY          = vga_write_scheduler_pkg::NY_DEFAULT,
  parameter int COLOR_DEPTH = vga_write_scheduler_pkg::COLOR_DEPTH_DEFAULT,
  parameter int MAX_BURST   = vga_write_scheduler_pkg::MAX_BURST_DEFAULT
) (
  input logic                  Clock,
  input logic                  Resetn,
  vga_write_scheduler_if.slave bus
);
  import vga_write_scheduler_pkg::*;

  localparam int OWNER_W = idx_w(NREQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  sched_state_e           state_q, state_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic [STALL_W-1:0]     stall_q, stall_d;

  logic                   wr_q;
  logic [nX-1:0]          x_q;
  logic [nY-1:0]          y_q;
  logic [COLOR_DEPTH-1:0] color_q;

  logic                   pick_vld;
  logic [OWNER_W-1:0]     pick_sel;
  logic                   accept;
  logic                   release_burst;
  logic [OWNER_W-1:0]     ptr_after_owner;
  logic [nX-1:0]          x_sel;
  logic [nY-1:0]          y_sel;
  logic [COLOR_DEPTH-1:0] color_sel;

  vga_write_scheduler_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (OWNER_W)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .sel_o   (pick_sel)
  );

  // Only the granted lane can be accepted, so an ungranted requester's
  // pixel never reaches the write port.
  assign accept = |(grant_q & bus.req);

  assign ptr_after_owner = (owner_q == OWNER_W'(NREQ - 1)) ? '0
                                                           : owner_q + 1'b1;

  // Pixel lane of the current owner.
  always_comb begin
    x_sel     = '0;
    y_sel     = '0;
    color_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        x_sel     = bus.x_in[i*nX +: nX];
        y_sel     = bus.y_in[i*nY +: nY];
        color_sel = bus.color_in[i*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    burst_d       = burst_q;
    stall_d       = stall_q;
    release_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_HOLD;
          grant_d = NREQ'(1) << pick_sel;
          owner_d = pick_sel;
          burst_d = '0;
          stall_d = '0;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          stall_d = '0;
          burst_d = burst_q + 1'b1;
          // The MAX_BURST-th pixel ends the burst, so the counter never
          // needs to go past MAX_BURST.
          if (bus.last[owner_q] || burst_q == BURST_W'(MAX_BURST - 1))
            release_burst = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
          if (stall_q == STALL_W'(STALL_LIMIT - 1))
            release_burst = 1'b1;
        end
        if (release_burst) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_after_owner;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      stall_q <= '0;
      wr_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
      wr_q    <= accept;
      if (accept) begin
        x_q     <= x_sel;
        y_q     <= y_sel;
        color_q <= color_sel;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == ST_HOLD);
  assign bus.VGA_write = wr_q;
  assign bus.VGA_x     = x_q;
  assign bus.VGA_y     = y_q;
  assign bus.VGA_color = color_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Bench for vga_write_scheduler: directed scenarios plus random traffic,
// compared every cycle against a burst-level reference model.
module tb_vga_write_scheduler;
  import vga_write_scheduler_pkg::*;

  localparam int NR   = 4;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int CW   = 9;
  localparam int MAXB = 8;

  logic Clock  = 1'b0;
  logic Resetn = 1'b1;
  always #5 Clock = ~Clock;

  vga_write_scheduler_if #(.NREQ(NR), .nX(XW), .nY(YW), .COLOR_DEPTH(CW)) bus();

  vga_write_scheduler #(
    .NREQ(NR), .nX(XW), .nY(YW), .COLOR_DEPTH(CW), .MAX_BURST(MAXB)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Requester behaviour
  logic [NR-1:0] want;
  int  blen[NR];
  int  pc[NR];
  bit  fix_data;
  bit  rand_blen;

  // Reference model: who holds the bus, where the rotation resumes,
  // how far the current burst got, and the last pixel written.
  bit m_hold;
  int m_owner, m_ptr, m_cnt, m_stall;
  bit m_wr;
  int m_x, m_y, m_c;

  int g_log[$];
  int w_log[$];
  int o_log[$];

  int exp_g28[8]  = '{1, 1, 1, 0, 2, 2, 2, 0};
  int exp_w28[8]  = '{0, 1, 1, 1, 0, 1, 1, 1};
  int exp_g29[13] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 4, 4, 0, 2};
  int exp_w29[13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
  int exp_g33[9]  = '{1, 0, 2, 0, 4, 0, 8, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
    m_wr = 0; m_x = 0; m_y = 0; m_c = 0;
    for (int i = 0; i < NR; i++) pc[i] = 0;
  endtask

  task automatic clear_logs();
    g_log.delete(); w_log.delete(); o_log.delete();
  endtask

  task automatic check_outputs();
    chk("grant",     32'(bus.grant),     m_hold ? (32'd1 << m_owner) : 32'd0);
    chk("owner",     32'(bus.owner),     32'(m_owner));
    chk("busy",      32'(bus.busy),      32'(m_hold));
    chk("VGA_write", 32'(bus.VGA_write), 32'(m_wr));
    chk("VGA_x",     32'(bus.VGA_x),     32'(m_x));
    chk("VGA_y",     32'(bus.VGA_y),     32'(m_y));
    chk("VGA_color", 32'(bus.VGA_color), 32'(m_c));
  endtask

  // One clock: present inputs, advance the model, compare after the edge.
  task automatic step();
    logic [NR-1:0] ls;
    int xs[NR];
    int ys[NR];
    int cs[NR];
    int acc;
    int o;
    bit found;
    bit rel;
    for (int i = 0; i < NR; i++) begin
      ls[i] = (pc[i] >= blen[i] - 1);
      if (fix_data && i == REQ_SCORE) begin
        xs[i] = 639; ys[i] = 479; cs[i] = 511;
      end else begin
        xs[i] = int'($urandom_range(0, 1023));
        ys[i] = int'($urandom_range(0, 511));
        cs[i] = int'($urandom_range(0, 511));
      end
      bus.x_in[i*XW +: XW]     = XW'(xs[i]);
      bus.y_in[i*YW +: YW]     = YW'(ys[i]);
      bus.color_in[i*CW +: CW] = CW'(cs[i]);
    end
    bus.req  = want;
    bus.last = ls;

    acc = -1;
    rel = 0;
    if (!m_hold) begin
      m_wr  = 0;
      found = 0;
      for (int k = 0; k < NR; k++) begin
        o = (m_ptr + k) % NR;
        if (!found && want[o]) begin found = 1; m_owner = o; end
      end
      if (found) begin m_hold = 1; m_cnt = 0; m_stall = 0; end
    end else if (want[m_owner]) begin
      acc = m_owner;
      m_wr = 1; m_x = xs[acc]; m_y = ys[acc]; m_c = cs[acc];
      m_cnt++; m_stall = 0;
      if (ls[acc] || m_cnt == MAXB) rel = 1;
    end else begin
      m_wr = 0;
      m_stall++;
      if (m_stall == STALL_LIMIT) rel = 1;
    end
    if (rel) begin m_hold = 0; m_ptr = (m_owner + 1) % NR; end

    if (acc >= 0) begin
      if (ls[acc]) begin
        pc[acc] = 0;
        if (rand_blen) blen[acc] = int'($urandom_range(1, 12));
      end else begin
        pc[acc]++;
      end
    end

    @(posedge Clock);
    #1;
    check_outputs();
    g_log.push_back(int'(bus.grant));
    w_log.push_back(int'(bus.VGA_write));
    o_log.push_back(int'(bus.owner));
  endtask

  task automatic run(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant),     32'd0);
    chk({tag, "_write"}, 32'(bus.VGA_write), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_owner"}, 32'(bus.owner),     32'd0);
    chk({tag, "_x"},     32'(bus.VGA_x),     32'd0);
    chk({tag, "_y"},     32'(bus.VGA_y),     32'd0);
    chk({tag, "_color"}, 32'(bus.VGA_color), 32'd0);
  endtask

  // Reset applied between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    Resetn = 1'b0;
    want = '0;
    bus.req = '0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    int ex;
    want = '0; fix_data = 0; rand_blen = 0;
    for (int i = 0; i < NR; i++) begin blen[i] = 3; pc[i] = 0; end
    bus.req = '0; bus.last = '0; bus.x_in = '0; bus.y_in = '0; bus.color_in = '0;
    model_reset();

    #1 Resetn = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check_reset_values("reset");
    Resetn = 1'b1;

    // Two 3-pixel bursts, requesters 0 then 1, one idle cycle between.
    want = 4'b0011;
    clear_logs();
    run(8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("r28_grant[%0d]", k), 32'(g_log[k]), 32'(exp_g28[k]));
      chk($sformatf("r28_write[%0d]", k), 32'(w_log[k]), 32'(exp_w28[k]));
    end
    want = '0;
    run(2);

    // Endless burst from 1 cut at MAX_BURST; 2 served before 1 resumes.
    for (int i = 0; i < NR; i++) pc[i] = 0;
    blen[1] = 1000; blen[2] = 2;
    want = 4'b0010;
    clear_logs();
    for (int s = 0; s < 13; s++) begin
      if (s == 3) want[2] = 1'b1;
      step();
    end
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("r29_grant[%0d]", k), 32'(g_log[k]), 32'(exp_g29[k]));
      chk($sformatf("r29_write[%0d]", k), 32'(w_log[k]), 32'(exp_w29[k]));
    end
    want = '0;
    run(20);

    // Requester 0: 5-cycle gap keeps the grant; 16-cycle gap releases it.
    for (int i = 0; i < NR; i++) pc[i] = 0;
    blen[0] = 6; blen[1] = 1000;
    clear_logs();
    for (int s = 1; s <= 30; s++) begin
      if (s >= 4 && s <= 8)  want = 4'b0000;
      else if (s <= 13)      want = 4'b0001;
      else                   want = 4'b0010;
      step();
    end
    wcount = 0;
    for (int k = 0; k < 12; k++) wcount += w_log[k];
    chk("r30_burst_writes", 32'(wcount), 32'd6);
    for (int k = 3; k <= 7; k++)
      chk($sformatf("r30_gap_write[%0d]", k), 32'(w_log[k]), 32'd0);
    for (int k = 0; k < 30; k++) begin
      if (k <= 10 || (k >= 12 && k <= 27)) ex = 1;
      else if (k == 29)                    ex = 2;
      else                                 ex = 0;
      chk($sformatf("r30_grant[%0d]", k), 32'(g_log[k]), 32'(ex));
    end
    chk("r30_owner_after_abandon", 32'(o_log[29]), 32'd1);
    want = '0;
    run(20);

    // Corner pixel from the score writer.
    for (int i = 0; i < NR; i++) pc[i] = 0;
    blen[REQ_SCORE] = 1;
    fix_data = 1;
    want = 4'b0100;
    clear_logs();
    run(2);
    chk("r31_write_e1", 32'(w_log[0]), 32'd0);
    chk("r31_write_e2", 32'(w_log[1]), 32'd1);
    chk("r31_x",        32'(bus.VGA_x),     32'd639);
    chk("r31_y",        32'(bus.VGA_y),     32'd479);
    chk("r31_color",    32'(bus.VGA_color), 32'h1FF);
    want = '0;
    fix_data = 0;
    step();
    chk("r31_write_off", 32'(bus.VGA_write), 32'd0);
    chk("r31_x_hold",    32'(bus.VGA_x),     32'd639);

    // Reset in the middle of a banner burst.
    for (int i = 0; i < NR; i++) pc[i] = 0;
    blen[REQ_BANNER] = 10;
    want = 4'b1000;
    run(4);
    chk("r32_mid_burst_write", 32'(bus.VGA_write), 32'd1);
    async_reset("r32_rst");
    blen[0] = 2; blen[3] = 2;
    want = 4'b1001;
    step();
    chk("r32_first_grant", 32'(bus.grant), 32'd1);
    chk("r32_first_owner", 32'(bus.owner), 32'd0);
    async_reset("r33_rst");

    // Everyone requesting, single-pixel bursts: strict rotation.
    for (int i = 0; i < NR; i++) blen[i] = 1;
    want = 4'b1111;
    clear_logs();
    run(9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("r33_grant[%0d]", k), 32'(g_log[k]), 32'(exp_g33[k]));
    want = '0;
    run(20);

    // Random traffic.
    rand_blen = 1;
    for (int i = 0; i < NR; i++) begin
      pc[i] = 0;
      blen[i] = int'($urandom_range(1, 12));
    end
    for (int s = 0; s < 3000; s++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 5) == 0) want[i] = ~want[i];
      if (s == 1500) async_reset("rand_rst");
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
